// File: rtl/fir_sym_seq.sv
// Time-multiplexed symmetric FIR: a circular sample buffer feeds one mirrored
// pair per clock through pre-add, coefficient multiply and accumulate.
module fir_sym_seq #(
  parameter int WIDTH = 24,
  parameter int TAP   = 101,
  parameter int CW    = 18,
  parameter int SHIFT = 17,
  localparam int NPAIR = (TAP + 1) / 2,
  localparam int AW    = $clog2(NPAIR)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data,
  output logic [AW-1:0]           coef_addr,
  input  logic signed [CW-1:0]    coef_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_data
);

  // state  | meaning
  // S_IDLE | waiting for a sample; in_ready high unless clear
  // S_MAC  | one mirrored pair per clock, k = coef_addr
  // S_DONE | result held on out_data until out_ready
  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

  localparam int MID   = (TAP - 1) / 2;
  localparam int PW    = $clog2(TAP);
  localparam int PRD_W = WIDTH + 1 + CW;
  localparam int ACC_W = WIDTH + 1 + CW + AW;
  localparam logic [PW-1:0] P_LAST = PW'(TAP - 1);
  localparam logic [AW-1:0] K_MID  = AW'(MID);
  localparam logic [AW-1:0] K_LAST = AW'(NPAIR - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  state_t                  r_state, w_state_nxt;
  logic signed [WIDTH-1:0] r_buf [TAP];
  logic [PW-1:0]           r_wr_ptr, r_rd_a, r_rd_b;
  logic [AW-1:0]           r_k;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [WIDTH-1:0] r_out_data;

  logic                    w_accept, w_last;
  logic [PW-1:0]           w_wr_nxt;
  logic signed [WIDTH-1:0] w_x_a, w_x_b;
  logic signed [WIDTH:0]   w_pre;
  logic signed [PRD_W-1:0] w_prod;
  logic signed [ACC_W-1:0] w_acc_nxt, w_acc_shr;
  logic signed [WIDTH-1:0] w_sat;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == P_LAST) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [PW-1:0] f_dec(input logic [PW-1:0] p);
    return (p == '0) ? P_LAST : p - PW'(1);
  endfunction

  assign w_accept  = (r_state == S_IDLE) && in_valid && !clear;
  assign w_last    = (r_k == K_LAST);
  assign w_wr_nxt  = f_inc(r_wr_ptr);
  assign in_ready  = (r_state == S_IDLE) && !clear;
  assign out_valid = (r_state == S_DONE);
  assign out_data  = r_out_data;
  assign coef_addr = r_k;

  // rd_a walks back from the newest sample, rd_b forward from the oldest
  assign w_x_a = r_buf[r_rd_a];
  assign w_x_b = r_buf[r_rd_b];

  always_comb begin
    if (r_k == K_MID) w_pre = (WIDTH+1)'(w_x_a);
    else              w_pre = (WIDTH+1)'(w_x_a) + (WIDTH+1)'(w_x_b);
  end

  assign w_prod    = PRD_W'(w_pre) * PRD_W'(coef_data);
  assign w_acc_nxt = r_acc + ACC_W'(w_prod);
  assign w_acc_shr = w_acc_nxt >>> SHIFT;

  always_comb begin
    if (w_acc_shr > SAT_MAX)      w_sat = SAT_MAX[WIDTH-1:0];
    else if (w_acc_shr < SAT_MIN) w_sat = SAT_MIN[WIDTH-1:0];
    else                          w_sat = w_acc_shr[WIDTH-1:0];
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_MAC;
      S_MAC:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (clear) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAP; i++) r_buf[i] <= '0;
      r_wr_ptr   <= '0;
      r_rd_a     <= '0;
      r_rd_b     <= '0;
      r_k        <= '0;
      r_acc      <= '0;
      r_out_data <= '0;
    end else if (clear) begin
      for (int i = 0; i < TAP; i++) r_buf[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_a   <= '0;
      r_rd_b   <= '0;
      r_k      <= '0;
      r_acc    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_buf[w_wr_nxt] <= in_data;
          r_wr_ptr        <= w_wr_nxt;
          r_rd_a          <= w_wr_nxt;
          r_rd_b          <= f_inc(w_wr_nxt);
          r_acc           <= '0;
          r_k             <= '0;
        end
        S_MAC: begin
          r_acc  <= w_acc_nxt;
          r_rd_a <= f_dec(r_rd_a);
          r_rd_b <= f_inc(r_rd_b);
          if (w_last) r_out_data <= w_sat;
          else        r_k <= r_k + AW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
